// File: rtl/led_pulse_monitor_if.sv
// Readback record and valid/ack handshake between led_pulse_monitor and the processor.
// The master side produces the capture record. The slave side consumes the record and returns RD_ACK.
interface led_pulse_monitor_if #(
  parameter int unsigned DELAY_WIDTH = 24,
  parameter int unsigned PWID_WIDTH  = 16
);
  localparam int unsigned FLAG_WIDTH = 4;
  localparam int unsigned CNT_WIDTH  = 16;

  logic [DELAY_WIDTH-1:0] LED_DELAY_OUT;
  logic [PWID_WIDTH-1:0]  LED_WIDTH_OUT;
  logic [FLAG_WIDTH-1:0]  LED_FLAGS;
  logic                   STATUS_VALID;
  logic                   OVERRUN;
  logic [CNT_WIDTH-1:0]   PULSE_COUNT;
  logic [CNT_WIDTH-1:0]   MISSED_COUNT;
  logic                   RD_ACK;

  modport master (
    output LED_DELAY_OUT, LED_WIDTH_OUT, LED_FLAGS, STATUS_VALID, OVERRUN,
           PULSE_COUNT, MISSED_COUNT,
    input  RD_ACK
  );

  modport slave (
    input  LED_DELAY_OUT, LED_WIDTH_OUT, LED_FLAGS, STATUS_VALID, OVERRUN,
           PULSE_COUNT, MISSED_COUNT,
    output RD_ACK
  );
endinterface

// File: rtl/led_pulse_monitor.sv
// LED flasher readback: measures the delay from 1PPS to the LED pulse and the pulse width, and flags seconds with no flash.
// The flash and miss counters exist only when LED_MON_COUNTERS_EN is defined; otherwise they read as zero.
module led_pulse_monitor #(
  parameter int unsigned DELAY_WIDTH = 24,
  parameter int unsigned PWID_WIDTH  = 16
) (
  input  logic               CLK120,
  input  logic               RESET,
  input  logic               ONE_PPS,
  input  logic               LEDBAR,
  input  logic               TRG_FLAG,
  input  logic               EXPECT_PPS,
  led_pulse_monitor_if.master rb
);
  localparam int unsigned FLAG_WIDTH = 4;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef enum logic [1:0] {IDLE, ARMED, PULSE} state_t;

  state_t                 r_state;
  logic                   r_pps_meta, r_pps_sync, r_pps_prev;
  logic                   r_ledbar_prev, r_led_qual;
  logic [DELAY_WIDTH-1:0] r_dly_cnt, r_dly_lat;
  logic                   r_dly_sat, r_dly_lat_sat;
  logic [PWID_WIDTH-1:0]  r_wid_cnt;
  logic                   r_wid_sat, r_manual, r_trg;
  logic [DELAY_WIDTH-1:0] r_delay_out;
  logic [PWID_WIDTH-1:0]  r_width_out;
  logic [FLAG_WIDTH-1:0]  r_flags;
  logic                   r_valid, r_overrun;

  logic                   w_pps_edge, w_led_fall, w_led_rise;
  logic                   w_dly_full, w_wid_full, w_trg_any, w_cap, w_load;
  logic [DELAY_WIDTH-1:0] w_dly_inc;
  logic [PWID_WIDTH-1:0]  w_wid_inc;

  assign w_pps_edge = r_pps_sync & ~r_pps_prev;
  // r_led_qual keeps a LEDBAR held low across reset release from looking like a fall.
  assign w_led_fall = r_led_qual & r_ledbar_prev & ~LEDBAR;
  assign w_led_rise = ~r_ledbar_prev & LEDBAR;

  assign w_dly_full = &r_dly_cnt;
  assign w_dly_inc  = w_dly_full ? r_dly_cnt : r_dly_cnt + DELAY_WIDTH'(1);
  assign w_wid_full = &r_wid_cnt;
  assign w_wid_inc  = w_wid_full ? r_wid_cnt : r_wid_cnt + PWID_WIDTH'(1);
  assign w_trg_any  = r_trg | TRG_FLAG;
  assign w_cap      = (r_state == PULSE) & w_led_rise;
  assign w_load     = w_cap & (~r_valid | rb.RD_ACK);

`ifdef LED_MON_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_pulse_cnt, r_miss_cnt;
  assign rb.PULSE_COUNT  = r_pulse_cnt;
  assign rb.MISSED_COUNT = r_miss_cnt;
`else
  assign rb.PULSE_COUNT  = '0;
  assign rb.MISSED_COUNT = '0;
`endif

  assign rb.LED_DELAY_OUT = r_delay_out;
  assign rb.LED_WIDTH_OUT = r_width_out;
  assign rb.LED_FLAGS     = r_flags;
  assign rb.STATUS_VALID  = r_valid;
  assign rb.OVERRUN       = r_overrun;

  // Measurement FSM and record/handshake registers.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_pps_meta    <= 1'b0;
      r_pps_sync    <= 1'b0;
      r_pps_prev    <= 1'b0;
      r_ledbar_prev <= 1'b1;
      r_led_qual    <= 1'b0;
      r_dly_cnt     <= '0;
      r_dly_sat     <= 1'b0;
      r_dly_lat     <= '0;
      r_dly_lat_sat <= 1'b0;
      r_wid_cnt     <= '0;
      r_wid_sat     <= 1'b0;
      r_manual      <= 1'b0;
      r_trg         <= 1'b0;
      r_delay_out   <= '0;
      r_width_out   <= '0;
      r_flags       <= '0;
      r_valid       <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef LED_MON_COUNTERS_EN
      r_pulse_cnt   <= '0;
      r_miss_cnt    <= '0;
`endif
    end else begin
      r_pps_meta    <= ONE_PPS;
      r_pps_sync    <= r_pps_meta;
      r_pps_prev    <= r_pps_sync;
      r_ledbar_prev <= LEDBAR;
      r_led_qual    <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_led_fall) begin
            r_state       <= PULSE;
            r_manual      <= 1'b1;
            r_dly_lat     <= '0;
            r_dly_lat_sat <= 1'b0;
            r_wid_cnt     <= PWID_WIDTH'(1);
            r_wid_sat     <= 1'b0;
            r_trg         <= TRG_FLAG;
          end else if (w_pps_edge && EXPECT_PPS) begin
            r_state   <= ARMED;
            r_dly_cnt <= '0;
            r_dly_sat <= 1'b0;
          end
        end
        ARMED: begin
          // The fall cycle counts as a delay cycle, so the latched value is the incremented count.
          if (w_led_fall) begin
            r_state       <= PULSE;
            r_manual      <= 1'b0;
            r_dly_lat     <= w_dly_inc;
            r_dly_lat_sat <= r_dly_sat | w_dly_full;
            r_wid_cnt     <= PWID_WIDTH'(1);
            r_wid_sat     <= 1'b0;
            r_trg         <= TRG_FLAG;
          end else if (!EXPECT_PPS) begin
            r_state <= IDLE;
          end else if (w_pps_edge) begin
            r_dly_cnt <= '0;
            r_dly_sat <= 1'b0;
`ifdef LED_MON_COUNTERS_EN
            r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
`endif
          end else begin
            r_dly_cnt <= w_dly_inc;
            r_dly_sat <= r_dly_sat | w_dly_full;
          end
        end
        PULSE: begin
          r_trg <= w_trg_any;
          if (!LEDBAR) begin
            r_wid_cnt <= w_wid_inc;
            r_wid_sat <= r_wid_sat | w_wid_full;
          end
          if (w_led_rise) begin
`ifdef LED_MON_COUNTERS_EN
            r_pulse_cnt <= r_pulse_cnt + CNT_WIDTH'(1);
`endif
            if (EXPECT_PPS && !r_manual) begin
              r_state   <= ARMED;
              r_dly_cnt <= '0;
              r_dly_sat <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // A capture that finds an unread record is dropped and flagged as an overrun.
      if (w_load) begin
        r_delay_out <= r_dly_lat;
        r_width_out <= r_wid_cnt;
        r_flags     <= {r_wid_sat, r_dly_lat_sat, w_trg_any, r_manual};
        r_valid     <= 1'b1;
        r_overrun   <= 1'b0;
      end else if (w_cap) begin
        r_overrun <= 1'b1;
      end else if (rb.RD_ACK && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: doc/led_pulse_monitor.md
Name: led_pulse_monitor

Overview:
- Readback end of the LED flasher path in sde_trigger; observes LEDBAR and TRG_FLAG produced by the LED controller.
- Measures delay from the synchronized 1PPS edge to the LED pulse start, and the LED pulse width, both in CLK120 cycles.
- Detects PPS seconds with no flash, and presents one capture record per flash to the processor via a valid/ack handshake.

Parameters:
DELAY_WIDTH, 24, width of the delay counter and of LED_DELAY_OUT
PWID_WIDTH, 16, width of the pulse-width counter and of LED_WIDTH_OUT

Ports:
CLK120  in  1  120 MHz system clock
RESET  in  1  synchronous, active-high reset
ONE_PPS  in  1  asynchronous 1PPS; 2-flop synchronized internally, then rising-edge detected
LEDBAR  in  1  LED drive, active-low, CLK120 domain
TRG_FLAG  in  1  LED trigger flag, CLK120 domain
EXPECT_PPS  in  1  1 = PPS-scheduled flashes expected (mirrors LED_ENAPPS)
RD_ACK  in  1  one-cycle strobe: processor has read the record
LED_DELAY_OUT  out  DELAY_WIDTH  captured PPS-to-LED delay
LED_WIDTH_OUT  out  PWID_WIDTH  captured LED-low width
LED_FLAGS  out  4  [0] MANUAL, [1] TRG_SEEN, [2] DELAY_SAT, [3] WIDTH_SAT
STATUS_VALID  out  1  record available
OVERRUN  out  1  sticky: a record was dropped
PULSE_COUNT  out  16  flashes captured (optional feature)
MISSED_COUNT  out  16  PPS seconds without a flash (optional feature)

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Internal previous-LEDBAR register = 1. A LEDBAR held low through reset release is therefore not a fall.
- LED fall: previous LEDBAR = 1 and current LEDBAR = 0. LED rise is the reverse.
- States: IDLE, ARMED, PULSE.
- IDLE:
  - PPS edge with EXPECT_PPS=1: go to ARMED, delay counter = 0.
  - LED fall: go to PULSE, MANUAL=1, captured delay = 0, width counter = 1.
- ARMED:
  - Delay counter increments each cycle, saturating at all-ones; saturation sets DELAY_SAT.
  - LED fall: latch delay counter value, MANUAL=0, width counter = 1, go to PULSE.
  - PPS edge with no fall: MISSED_COUNT += 1, delay counter = 0, DELAY_SAT cleared, stay ARMED.
  - PPS edge and LED fall in the same cycle: the fall wins; no miss is counted.
  - EXPECT_PPS=0: go to IDLE with no miss counted.
- PULSE:
  - Width counter increments each cycle LEDBAR=0, saturating at all-ones; saturation sets WIDTH_SAT.
  - TRG_SEEN is set if TRG_FLAG=1 in any cycle from entry to PULSE through the capture cycle.
  - PPS edges are ignored.
  - LED rise triggers capture:
    - Load the output records and flags.
    - PULSE_COUNT += 1.
    - Return to ARMED (delay counter = 0) if EXPECT_PPS=1 and MANUAL=0; otherwise return to IDLE.
- Measured delay N: LEDBAR is first sampled low N cycles after the cycle in which the PPS edge is detected.
- Measured width W: the number of cycles LEDBAR is sampled low.
- Capture to STATUS_VALID=1 takes 1 cycle (outputs registered).
- Handshake:
  - RD_ACK clears STATUS_VALID and OVERRUN.
  - Capture while STATUS_VALID=1 and RD_ACK=0: record is discarded, outputs keep the old record, OVERRUN is set.
  - Capture and RD_ACK in the same cycle: the new record loads, STATUS_VALID stays 1, no overrun.
  - RD_ACK while STATUS_VALID=0: no effect.
- Counters PULSE_COUNT and MISSED_COUNT wrap modulo 2^16.
- RESET mid-pulse or mid-delay: immediate return to IDLE, partial measurement discarded, outputs cleared.

Optional Feature:
- Macro LED_MON_COUNTERS_EN.
- Defined: PULSE_COUNT and MISSED_COUNT are implemented as described above.
- Undefined: both outputs are tied to 0 and the counter logic is removed. Miss detection still restarts the delay counter.

Test Plan:
- EXPECT_PPS=1; PPS edge; LEDBAR low 500 cycles after the detect cycle for 40 cycles; TRG_FLAG high 3 cycles → STATUS_VALID=1, DELAY_OUT=500, WIDTH_OUT=40, FLAGS=0b0010, PULSE_COUNT=1.
- EXPECT_PPS=0; LEDBAR low 10 cycles with no PPS → DELAY_OUT=0, WIDTH_OUT=10, MANUAL=1, TRG_SEEN=0.
- EXPECT_PPS=1; three PPS edges with no LEDBAR activity → MISSED_COUNT=2 (the second and third edges count), state ARMED, STATUS_VALID=0.
- Two flashes with no RD_ACK → outputs hold the first record, OVERRUN=1. Then RD_ACK → STATUS_VALID=0, OVERRUN=0.
- RD_ACK asserted in the same cycle as the second capture → second record loaded, STATUS_VALID=1, OVERRUN=0.
- DELAY_WIDTH=4, delay 20 cycles → DELAY_OUT=15, DELAY_SAT=1. Separately, RESET asserted with LEDBAR low, then released while LEDBAR is still low → no capture until the next high-to-low transition.
